// File: rtl/uart_pkg.sv
// uart_pkg: shared frame constant, arbiter state type and baud divisor helper.
package uart_pkg;
    localparam int FRAME_BITS = 10;
    typedef enum logic {IDLE, OWN} arb_state_t;
    function automatic int baud_div(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 shifter, DIV cycles per bit, bit timer restarted on every load.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       idle,
    output logic       tx
);
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TMAX = TW'(DIV - 1);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);
    logic [TW-1:0] timer;
    logic [3:0] bit_idx;
    logic [8:0] shreg;
    logic active, tick, done;
    assign tick = (timer == TMAX);
    assign done = active && tick && (bit_idx == LAST_BIT);
    // idle already in the final stop-bit cycle so a reload follows with no gap
    assign idle = ~active | done;
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            tx      <= 1'b1;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '1;
        end else if (load) begin
            active  <= 1'b1;
            tx      <= 1'b0;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= {1'b1, data};
        end else if (active) begin
            timer <= tick ? '0 : timer + 1'b1;
            if (tick) begin
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
                bit_idx <= bit_idx + 1'b1;
                active  <= ~done;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin message-locked sharing of one 8N1 tx line; UART_ARB_TIMEOUT_EN adds stall eviction.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int CLOCK_FREQ     = 30000000,
    parameter int BAUD_RATE      = 115200,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               abort,
    output logic               tx
);
    localparam int DIV = baud_div(CLOCK_FREQ, BAUD_RATE);
    localparam int PW = $clog2(N_REQ);
    if (N_REQ < 2 || N_REQ > 8 || DIV < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported parameter set");
    end
    arb_state_t state, state_n;
    logic [N_REQ-1:0] grant_n;
    logic [PW-1:0] owner, owner_n, ptr, ptr_n, sel, owner_inc;
    logic ser_idle, xfer, last, found;
    logic [7:0] byte_d;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STALL_LIM = SW'(TIMEOUT_CYCLES - 1);
    logic [SW-1:0] stall, stall_n;
    logic abort_r, abort_n;
    assign abort = abort_r;
`else
    assign abort = 1'b0;
`endif
    assign req_ready = (state == OWN && ser_idle) ? grant : '0;
    assign xfer      = |(req_valid & req_ready);
    assign byte_d    = req_data[{owner, 3'b000} +: 8];
    assign last      = req_last[owner];
    assign owner_inc = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign busy      = (state == OWN) | ~ser_idle;
    always_comb begin
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid[(int'(ptr) + k) % N_REQ]) begin
                sel   = PW'((int'(ptr) + k) % N_REQ);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_n = state;
        grant_n = grant;
        owner_n = owner;
        ptr_n   = ptr;
`ifdef UART_ARB_TIMEOUT_EN
        stall_n = stall;
        abort_n = 1'b0;
`endif
        if (state == IDLE) begin
            if (found) begin
                state_n = OWN;
                grant_n = N_REQ'(1) << sel;
                owner_n = sel;
`ifdef UART_ARB_TIMEOUT_EN
                stall_n = '0;
`endif
            end
        end else if (xfer && last) begin
            state_n = IDLE;
            grant_n = '0;
            ptr_n   = owner_inc;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (xfer) begin
            stall_n = '0;
        end else if (ser_idle) begin
            stall_n = stall + 1'b1;
            if (stall == STALL_LIM) begin
                abort_n = 1'b1;
                state_n = IDLE;
                grant_n = '0;
                ptr_n   = owner_inc;
            end
        end
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            ptr   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            stall   <= '0;
            abort_r <= 1'b0;
`endif
        end else begin
            state <= state_n;
            grant <= grant_n;
            owner <= owner_n;
            ptr   <= ptr_n;
`ifdef UART_ARB_TIMEOUT_EN
            stall   <= stall_n;
            abort_r <= abort_n;
`endif
        end
    end
    uart_tx_serializer #(.DIV(DIV)) u_ser (
        .clk  (clk),
        .rst  (rst),
        .load (xfer),
        .data (byte_d),
        .idle (ser_idle),
        .tx   (tx)
    );
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed steps with a byte/start-time scoreboard checked by a tx frame monitor.
module tb_uart_tx_arbiter;
    localparam int DIV = 10;
    typedef struct {
        logic [7:0] d;
        int         t;
    } exp_t;
    logic clk, rst, busy, abort, tx;
    logic [3:0] req_valid, req_last, req_ready, grant;
    logic [31:0] req_data;
    exp_t q[$];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int rdy_cnt [4] = '{default: 0};
    uart_tx_arbiter #(
        .N_REQ(4), .CLOCK_FREQ(1000000), .BAUD_RATE(100000), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant), .busy(busy), .abort(abort), .tx(tx)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (req_ready[i] === 1'b1) rdy_cnt[i] <= rdy_cnt[i] + 1;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic wait_xfer(output int i, output int t);
        int n = 0;
        exp_t e;
        i = -1;
        t = -1;
        while (!(|(req_valid & req_ready)) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("xfer_wait", n < 5000, 1);
        if (n < 5000) begin
            for (int k = 3; k >= 0; k--) if (req_valid[k] & req_ready[k]) i = k;
            e.d = req_data[8*i +: 8];
            e.t = cyc + 1;
            q.push_back(e);
            @(negedge clk);
            t = cyc;
        end
    endtask
    task automatic send(input int i, input logic [7:0] d, input logic l, output int t);
        int j;
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = d;
        req_last[i] = l;
        wait_xfer(j, t);
        chk("xfer_src", j, i);
    endtask
    task automatic drain();
        int n = 0;
        while ((busy !== 1'b0 || q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", n < 3000, 1);
        repeat (3) @(negedge clk);
    endtask
    initial begin : mon
        exp_t e;
        logic [9:0] fr;
        int bad, t0;
        bit drop;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                t0 = cyc;
                chk("frame_unexpected", q.size() == 0, 0);
                if (q.size() != 0) e = q.pop_front();
                else begin
                    e.d = 8'h00;
                    e.t = -1;
                end
                fr = {1'b1, e.d, 1'b0};
                bad = 0;
                drop = 0;
                for (int o = 0; o < 10*DIV; o++) begin
                    if (o != 0) @(negedge clk);
                    if (rst !== 1'b0) begin
                        drop = 1;
                        break;
                    end
                    if (tx !== fr[o/DIV]) bad++;
                end
                if (!drop) begin
                    chk("frame_start", t0, e.t);
                    chk("frame_bits", bad, 0);
                end
            end
        end
    end
    initial begin
        int t, t2, j, s, r, gbad, r0bad, ab;
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_grant", grant, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_abort", abort, 0);
        rst = 1'b0;
        @(negedge clk);
        s = cyc;
        send(0, 8'h66, 1'b1, t);
        chk("grant_latency", t, s + 2);
        chk("single_release", grant, 0);
        chk("single_busy", busy, 1);
        req_valid[0] = 1'b0;
        drain();
        r = rdy_cnt[1];
        send(1, "f", 1'b0, t);
        send(1, "l", 1'b0, t2);
        chk("b2b_period_1", t2 - t, 10*DIV);
        send(1, "a", 1'b1, t);
        chk("b2b_period_2", t - t2, 10*DIV);
        chk("b2b_release", grant, 0);
        req_valid[1] = 1'b0;
        drain();
        chk("b2b_ready_pulses", rdy_cnt[1] - r, 3);
        req_data[7:0] = 8'h55;
        req_last[0] = 1'b1;
        req_valid[0] = 1'b1;
        send(2, 8'h31, 1'b0, t);
        req_valid[2] = 1'b0;
        gbad = 0;
        r0bad = 0;
        ab = -1;
        for (int k = 0; k < 300; k++) begin
            if (abort === 1'b1) begin
                ab = cyc;
                break;
            end
            if (grant !== 4'b0100) gbad++;
            if (req_ready[0] !== 1'b0) r0bad++;
            @(negedge clk);
        end
        chk("lock_grant_held", gbad, 0);
        chk("lock_req0_blocked", r0bad, 0);
        chk("lock_tx_idle", tx, 1);
`ifdef UART_ARB_TIMEOUT_EN
        chk("abort_time", ab, t + 10*DIV - 1 + 50);
        @(negedge clk);
        chk("abort_one_cycle", abort, 0);
        wait_xfer(j, t2);
        chk("abort_next_src", j, 0);
        chk("abort_next_time", t2 - t, 10*DIV + 51);
        req_valid[0] = 1'b0;
`else
        chk("lock_no_abort", ab, -1);
        req_valid[0] = 1'b0;
        send(2, 8'h32, 1'b1, t2);
        chk("lock_release", grant, 0);
        req_valid[2] = 1'b0;
`endif
        drain();
        req_data[7:0] = 8'h77;
        req_last[0] = 1'b1;
        req_valid[0] = 1'b1;
        send(3, 8'h5A, 1'b1, t);
        chk("sim_release", grant, 0);
        req_valid[3] = 1'b0;
        @(negedge clk);
        chk("sim_grant0_t2", grant, 4'b0001);
        chk("sim_ready0_wait", req_ready, 0);
        wait_xfer(j, t2);
        chk("sim_src", j, 0);
        chk("sim_ready_delay", t2 - t, 10*DIV);
        req_valid[0] = 1'b0;
        drain();
        send(1, 8'hC3, 1'b1, t);
        req_valid[1] = 1'b0;
        while (cyc < t + 5*DIV + 3) @(negedge clk);
        chk("mrst_pre_tx", tx, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_tx", tx, 1);
        chk("mrst_grant", grant, 0);
        chk("mrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(3, 8'hA5, 1'b1, t);
        req_valid[3] = 1'b0;
        drain();
        for (int i = 0; i < 4; i++) begin
            req_data[8*i +: 8] = 8'hB0 + 8'(i);
            req_last[i] = 1'b1;
            req_valid[i] = 1'b1;
        end
        for (int k = 0; k < 5; k++) begin
            wait_xfer(j, t);
            chk("rr_order", j, k % 4);
            if (j >= 0 && k > 0) req_valid[j] = 1'b0;
        end
        drain();
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
